ttt_board_ctrl: RTL
===================

TTT_BOARD_CTRL -- requirements
Module: ttt_board_ctrl

Interface
REQ-001 Parameter FIRST_PLAYER, default 0, player who moves first after reset or new game (0 = X, 1 = O).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 new_game  input  1  one-cycle request to clear the board and restart.
REQ-005 play  input  1  move-valid strobe, sampled each rising edge.
REQ-006 pos  input  4  cell index 0..8 for the move; valid when play=1.
REQ-007 ready  output  1  high when a move can be accepted.
REQ-008 X  output  9  registered X occupancy; bit i = cell i.
REQ-009 O  output  9  registered O occupancy; bit i = cell i.
REQ-010 turn  output  1  player to move (0 = X, 1 = O).
REQ-011 move_cnt  output  4  number of accepted moves, 0..9.
REQ-012 win_x, win_o, draw, done  output  1 each  registered game result flags.
REQ-013 illegal  output  1  one-cycle pulse flagging a rejected move.

Function
REQ-014 FSM states SHALL be MOVE, CHECK and OVER.
REQ-015 ready SHALL equal (state==MOVE).
REQ-016 In MOVE, with play=1, pos<=8 and X[pos]|O[pos]=0, the next edge SHALL set bit pos of the turn player's vector, increment move_cnt and go to CHECK.
REQ-017 In MOVE, with play=1 and either pos>8 or the cell occupied, the next edge SHALL set illegal=1 for exactly one cycle; board, turn and move_cnt SHALL stay unchanged and the state SHALL remain MOVE.
REQ-018 In CHECK and OVER, play SHALL be ignored: no board change and no illegal pulse.
REQ-019 CHECK SHALL last exactly one cycle and evaluate the registered boards through two line_detect instances (8 lines: rows 012/345/678, columns 036/147/258, diagonals 048/246).
REQ-020 On exit from CHECK, if the mover completed a line, the corresponding win flag SHALL be set, done=1 and the state SHALL go to OVER.
REQ-021 Otherwise, if move_cnt==9, draw=1, done=1 and the state SHALL go to OVER.
REQ-022 Otherwise, turn SHALL toggle and the state SHALL return to MOVE.
REQ-023 A win on the 9th move SHALL set the win flag only; draw SHALL stay 0.
REQ-024 Latency: move accepted at edge N; board visible after edge N; result flags and the turn toggle visible after edge N+1.
REQ-025 Only the mover's win SHALL be checked; win_x and win_o SHALL never both be 1.
REQ-026 OVER SHALL hold all outputs until new_game or rst.
REQ-027 new_game=1 in any state SHALL behave exactly like rst on the next edge and SHALL take priority over play in the same cycle.

Reset
REQ-028 On rst: X=0, O=0, move_cnt=0, turn=FIRST_PLAYER, win_x=win_o=draw=done=illegal=0, state=MOVE (so ready=1 after the edge).
REQ-029 rst SHALL take priority over new_game and play, and SHALL take effect mid-game from any state.

Structure
REQ-030 A shared package ttt_pkg SHALL hold the state enum, the cell-count constant 9 and the constant PLAYER_X=0 / PLAYER_O=1.
REQ-031 One combinational sub-module, line_detect, SHALL take a 9-bit occupancy vector and output 1 when any of the 8 lines is complete; the controller SHALL instantiate it twice, once for X and once for O.

Verification
REQ-032 Reset: assert rst 2 cycles -> X=0, O=0, turn=0, move_cnt=0, ready=1, all flags 0.
REQ-033 X row win, moves X0,O3,X1,O4,X2 -> X=9'b000000111, O=9'b000011000, win_x=1, done=1, ready=0; a further play at pos 5 leaves the board unchanged.
REQ-034 Illegal moves: X4 then O plays 4 -> illegal pulses exactly 1 cycle, O=0, turn=1; O then plays pos=9 -> another illegal pulse; O then plays 0 -> accepted.
REQ-035 Draw, moves X4,O0,X8,O2,X1,O7,X6,O3,X5 -> X=9'b101110010, O=9'b010001101, move_cnt=9, draw=1, win_x=win_o=0, done=1.
REQ-036 Win on the last move, moves X0,O1,X2,O3,X5,O4,X7,O6,X8 -> X=9'b110100101, win_x=1, draw=0.
REQ-037 new_game and play asserted in the same cycle mid-game -> board cleared, move_cnt=0, no move recorded, turn=FIRST_PLAYER, ready=1.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared FSM states, board size and player encodings for the tic-tac-toe controller.
package ttt_pkg;
    typedef enum logic [1:0] {MOVE, CHECK, OVER} state_t;
    localparam int CELLS = 9;
    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;
endpackage

// File: rtl/line_detect.sv
// line_detect: flags a completed row, column or diagonal in one player's occupancy vector.
import ttt_pkg::*;
module line_detect (
    input  logic [CELLS-1:0] cells,
    output logic             hit
);
    assign hit = (&cells[2:0]) | (&cells[5:3]) | (&cells[8:6]) |
                 (cells[0] & cells[3] & cells[6]) |
                 (cells[1] & cells[4] & cells[7]) |
                 (cells[2] & cells[5] & cells[8]) |
                 (cells[0] & cells[4] & cells[8]) |
                 (cells[2] & cells[4] & cells[6]);
endmodule

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: accepts alternating moves, rejects illegal ones and
// resolves win/draw one cycle after each accepted move.
import ttt_pkg::*;
module ttt_board_ctrl #(
    parameter logic FIRST_PLAYER = PLAYER_X
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic             play,
    input  logic [3:0]       pos,
    output logic             ready,
    output logic [CELLS-1:0] X,
    output logic [CELLS-1:0] O,
    output logic             turn,
    output logic [3:0]       move_cnt,
    output logic             win_x,
    output logic             win_o,
    output logic             draw,
    output logic             done,
    output logic             illegal
);
    state_t state;
    logic x_line, o_line, in_range, free, mover_won;
    line_detect u_x (.cells(X), .hit(x_line));
    line_detect u_o (.cells(O), .hit(o_line));
    assign in_range  = pos < 4'(CELLS);
    assign free      = in_range && !(X[pos] || O[pos]);
    // turn still names the mover while in CHECK
    assign mover_won = (turn == PLAYER_O) ? o_line : x_line;
    assign ready     = (state == MOVE);
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state    <= MOVE;
            X        <= '0;
            O        <= '0;
            turn     <= FIRST_PLAYER;
            move_cnt <= '0;
            win_x    <= 1'b0;
            win_o    <= 1'b0;
            draw     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                MOVE: if (play) begin
                    if (free) begin
                        if (turn == PLAYER_O) O <= O | (9'b1 << pos);
                        else                  X <= X | (9'b1 << pos);
                        move_cnt <= move_cnt + 4'd1;
                        state    <= CHECK;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                CHECK: begin
                    if (mover_won) begin
                        win_x <= (turn == PLAYER_X);
                        win_o <= (turn == PLAYER_O);
                        done  <= 1'b1;
                        state <= OVER;
                    end else if (move_cnt == 4'(CELLS)) begin
                        draw  <= 1'b1;
                        done  <= 1'b1;
                        state <= OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= MOVE;
                    end
                end
                default: state <= OVER;
            endcase
        end
    end
endmodule
